csr_timer_unit: RTL
===================

Name: csr_timer_unit

Overview:
Parametrised multi-channel successor to the single CSR timer inside the CSR register file. It provides NUM_TIMERS independent countdown timers and a free-running 64-bit stable counter for rdcnt. Pending interrupts are sticky until cleared, and a shared prescaler sets the count rate. The unit sits beside the CSR file on the same CSR read/write bus and drives timer-interrupt bits into ESTAT.IS.

Parameters:
NUM_TIMERS, 2, number of timer channels (1..8)
TVAL_WID, 32, countdown width in bits (8..32); initval occupies bits [TVAL_WID-1:2]
TCFG_BASE, 'h41, CSR address of channel 0 TCFG
CH_STRIDE, 'h8, CSR address distance between channels
DIV, 1, prescaler ratio; timers advance once every DIV cycles (1..256)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr  in  14  CSR address (csr_addr_t)
we  in  1  CSR write enable, wb stage
wr_data  in  32  CSR write data
rd_data  out  32  combinational read data; 0 when unmapped
rd_hit  out  1  addr maps to a register in this unit
ti  out  NUM_TIMERS  per-channel sticky pending interrupt
ti_any  out  1  OR of ti
stable_cnt  out  64  free-running cycle counter

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Channel i address map: TCFG = TCFG_BASE + i*CH_STRIDE (offset 0), TVAL = +1 (read-only), TICLR = +3 (write-1-clear; reads 0). Every other address in the stride is unmapped.
- Reset values: en=0, periodic=0, initval=0, tval=0, pending=0, prescaler=0, stable_cnt=0. All outputs are therefore 0.
- TCFG write (we and addr match): en<=wr_data[0], periodic<=wr_data[1], initval<=wr_data[TVAL_WID-1:2], tval<={wr_data[TVAL_WID-1:2],2'b00}.
  - Takes effect at the same edge and overrides any countdown in that cycle.
  - Does not touch pending.
  - Writing with en=0 loads tval and holds it.
- TCFG read returns {0-ext initval, periodic, en}. TVAL read returns tval zero-extended to 32 bits.
- tick = (prescaler == DIV-1). The prescaler wraps to 0 on tick; it is free-running and unaffected by CSR writes. With DIV=1, tick is constant 1.
- On tick, when en and no TCFG write that cycle:
  - tval != 0: tval <= tval-1.
  - tval == 0 (expiry): pending <= 1.
    - If periodic: tval <= {initval,2'b00} and en stays 1.
    - Otherwise: en <= 0 and tval <= all-ones (TVAL_WID bits).
- Expiry with initval=0 and periodic=1 fires on every tick.
- Pending is visible on ti one cycle after the expiry edge.
- TICLR write with wr_data[0]=1 clears pending at that edge. If expiry coincides with the clear, set wins and pending stays 1.
- stable_cnt increments every cycle; it wraps from 2^64-1 to 0. It is not prescaled and not writable.
- Reset asserted mid-count returns all state to reset values immediately.
- Address aliasing from a bad parameter choice (channels overlapping) is illegal and is checked by an elaboration assertion.

Decomposition:
- Shared package (cpu_defs) holds:
  - timer_cfg_t struct {initval, periodic, en}
  - constants TCFG_OFS=0, TVAL_OFS=1, TICLR_OFS=3
- Sub-module `timer_channel`, one per channel via generate. It takes tick, cfg_we, clr, wr_data and outputs tval, cfg, pending.
- The top level owns address decode, the read mux, the prescaler and stable_cnt.

Test Plan:
- Reset, then idle: reads at 'h41/'h42/'h44 = 0, ti=0, rd_hit=1 at 'h41; stable_cnt reads 0,1,2 on successive cycles; read at 'h43 gives rd_data=0, rd_hit=0.
- One-shot: write 'h41=0x11 (en=1, initval=4). Then tval=0x10 and decrements; after 16 further edges tval=0; on the next edge ti[0]=1, TVAL reads 0xFFFF_FFFF, TCFG reads 0x10 (en cleared).
- Periodic: write 'h41=0x0B (initval=2, periodic). ti[0] sets 9 cycles after the write and tval reloads to 8. Write 'h44=1, and ti[0]=0 next cycle, then sets again 9 cycles after the previous expiry.
- Collision: TICLR write on the exact expiry edge leaves ti[0]=1. TCFG rewrite with 0x0 mid-count gives tval=0, no expiry, and ti is unchanged.
- Channel independence: write 'h49=0x05 (channel 1, initval=1, en); ti[1] asserts after 5 cycles, ti[0] stays 0, and ti_any follows.
- DIV=4 build: write 'h41=0x09 (tval=8). tval decrements once per 4 cycles and expires 36±3 cycles later; pulsing rst_n low mid-count clears tval, ti and stable_cnt immediately.

Source files
------------

// File: rtl/csr_timer_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs -- shared definitions for the CSR timer unit.
//
// Contents:
//   csr_addr_t   14-bit CSR address
//   timer_cfg_t  per-channel TCFG contents laid out exactly as the TCFG read
//                word {initval, periodic, en}; initval is sized for the widest
//                countdown (32 bits -> 30 bits of initval) and narrower builds
//                keep the unused upper bits at zero
//   *_OFS        register offsets inside one channel's address stride
//   chanAddr     address of a register of a given channel
// -----------------------------------------------------------------------------
package cpu_defs;

  typedef logic [13:0] csr_addr_t;

  typedef struct packed {
    logic [29:0] initval;
    logic        periodic;
    logic        en;
  } timer_cfg_t;

  localparam csr_addr_t TCFG_OFS  = 14'd0;
  localparam csr_addr_t TVAL_OFS  = 14'd1;
  localparam csr_addr_t TICLR_OFS = 14'd3;

  // Channel register address: base + channel*stride + register offset.
  function automatic csr_addr_t chanAddr(input int base, input int stride,
                                         input int ch, input csr_addr_t ofs);
    return csr_addr_t'(base + stride * ch) + ofs;
  endfunction

endpackage

// File: rtl/csr_timer_unit_timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel -- one countdown timer with a sticky pending flag.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick_i       prescaled count enable shared by all channels
//   cfgWe_i      TCFG write strobe for this channel
//   clr_i        TICLR write-1 strobe for this channel
//   wrData_i     CSR write data
//   tval_o       current countdown value
//   cfg_o        current configuration {initval, periodic, en}
//   pending_o    sticky interrupt pending
// -----------------------------------------------------------------------------
module timer_channel
  import cpu_defs::*;
#(
  parameter int TVAL_WID = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                cfgWe_i,
  input  logic                clr_i,
  input  logic [31:0]         wrData_i,
  output logic [TVAL_WID-1:0] tval_o,
  output timer_cfg_t          cfg_o,
  output logic                pending_o
);

  timer_cfg_t          cfg_q, cfg_d;
  logic [TVAL_WID-1:0] tval_q, tval_d;
  logic                pending_q, pending_d;
  logic                expire;

  // State registers for configuration, countdown and pending flag; all clear
  // asynchronously so a mid-count reset takes effect without waiting a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      tval_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      tval_q    <= tval_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic. A TCFG write replaces the configuration and reloads the
  // counter, overriding whatever the countdown would have done this cycle.
  // Otherwise, on a tick while enabled, the counter steps down; at zero it
  // expires, either reloading (periodic) or parking at all-ones with en cleared
  // (one-shot). Pending is set by expiry and cleared by TICLR, with set taking
  // priority when both land on the same edge.
  always_comb begin
    cfg_d  = cfg_q;
    tval_d = tval_q;
    expire = 1'b0;
    if (cfgWe_i) begin
      cfg_d                         = '0;
      cfg_d.en                      = wrData_i[0];
      cfg_d.periodic                = wrData_i[1];
      cfg_d.initval[TVAL_WID-3:0]   = wrData_i[TVAL_WID-1:2];
      tval_d                        = {wrData_i[TVAL_WID-1:2], 2'b00};
    end else if (tick_i && cfg_q.en) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TVAL_WID'(1);
      end else begin
        expire = 1'b1;
        if (cfg_q.periodic) begin
          tval_d = {cfg_q.initval[TVAL_WID-3:0], 2'b00};
        end else begin
          cfg_d.en = 1'b0;
          tval_d   = '1;
        end
      end
    end
    pending_d = (pending_q & ~clr_i) | expire;
  end

  assign tval_o    = tval_q;
  assign cfg_o     = cfg_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/csr_timer_unit.sv
// -----------------------------------------------------------------------------
// csr_timer_unit -- multi-channel CSR countdown timers plus a 64-bit stable
// counter, sharing the CSR read/write bus with the CSR register file.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   addr         CSR address
//   we           CSR write enable (wb stage)
//   wr_data      CSR write data
//   rd_data      combinational read data, 0 when the address is not ours
//   rd_hit       addr maps to a register in this unit
//   ti           per-channel sticky pending interrupt
//   ti_any       OR of ti
//   stable_cnt   free-running cycle counter
//
// Per channel i (base = TCFG_BASE + i*CH_STRIDE): TCFG at +0, TVAL at +1
// (read-only), TICLR at +3 (write-1-clear, reads 0).
// -----------------------------------------------------------------------------
module csr_timer_unit
  import cpu_defs::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TVAL_WID   = 32,
  parameter int TCFG_BASE  = 'h41,
  parameter int CH_STRIDE  = 'h8,
  parameter int DIV        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  csr_addr_t             addr,
  input  logic                  we,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rd_hit,
  output logic [NUM_TIMERS-1:0] ti,
  output logic                  ti_any,
  output logic [63:0]           stable_cnt
);

  // A stride below 4 makes a channel's TICLR land on the next channel's
  // registers, and the last channel must still fit in the CSR address space.
  if (CH_STRIDE < 4 || NUM_TIMERS < 1 || NUM_TIMERS > 8 ||
      TVAL_WID < 8 || TVAL_WID > 32 || DIV < 1 || DIV > 256 ||
      TCFG_BASE + (NUM_TIMERS - 1) * CH_STRIDE + 3 >= (1 << 14)) begin : gParamCheck
    $error("csr_timer_unit: illegal parameters (channel address aliasing or out of range)");
  end

  logic [7:0]  prescaler_q, prescaler_d;
  logic [63:0] stableCnt_q, stableCnt_d;
  logic        tick;

  logic [NUM_TIMERS-1:0] cfgWe;
  logic [NUM_TIMERS-1:0] tiClr;
  timer_cfg_t            chCfg  [NUM_TIMERS];
  logic [TVAL_WID-1:0]   chTval [NUM_TIMERS];

  // The prescaler runs free from reset and is never touched by CSR traffic,
  // so every channel sees the same tick phase. With DIV=1 it stays at 0 and
  // tick is permanently high.
  assign tick        = (prescaler_q == 8'(DIV - 1));
  assign prescaler_d = tick ? 8'd0 : prescaler_q + 8'd1;
  assign stableCnt_d = stableCnt_q + 64'd1;

  // Prescaler and stable counter registers; the stable counter simply wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      stableCnt_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      stableCnt_q <= stableCnt_d;
    end
  end

  // One channel per timer, each with its own write and clear decode.
  for (genvar g = 0; g < NUM_TIMERS; g++) begin : gChan
    localparam csr_addr_t CfgAddr = chanAddr(TCFG_BASE, CH_STRIDE, g, TCFG_OFS);
    localparam csr_addr_t ClrAddr = chanAddr(TCFG_BASE, CH_STRIDE, g, TICLR_OFS);

    assign cfgWe[g] = we && (addr == CfgAddr);
    assign tiClr[g] = we && (addr == ClrAddr) && wr_data[0];

    timer_channel #(
      .TVAL_WID (TVAL_WID)
    ) uChannel (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .cfgWe_i   (cfgWe[g]),
      .clr_i     (tiClr[g]),
      .wrData_i  (wr_data),
      .tval_o    (chTval[g]),
      .cfg_o     (chCfg[g]),
      .pending_o (ti[g])
    );
  end

  // Read mux. Legal parameters guarantee at most one match, so the loop just
  // picks up whichever channel register the address lands on. TICLR is a
  // mapped register that reads as zero.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (addr == chanAddr(TCFG_BASE, CH_STRIDE, i, TCFG_OFS)) begin
        rd_data = chCfg[i];
        rd_hit  = 1'b1;
      end else if (addr == chanAddr(TCFG_BASE, CH_STRIDE, i, TVAL_OFS)) begin
        rd_data = 32'(chTval[i]);
        rd_hit  = 1'b1;
      end else if (addr == chanAddr(TCFG_BASE, CH_STRIDE, i, TICLR_OFS)) begin
        rd_hit  = 1'b1;
      end
    end
  end

  assign ti_any     = |ti;
  assign stable_cnt = stableCnt_q;

endmodule
